// File: rtl/spi_ram_master_if.sv
// Host/SPI signal bundle for spi_ram_master: request/response side plus the serial pins.
interface spi_ram_master_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       err;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, cmd, wdata, MISO,
        output busy, done, rdata, rdata_valid, err, SS_n, MOSI
    );

    modport slave (
        output start, cmd, wdata, MISO,
        input  busy, done, rdata, rdata_valid, err, SS_n, MOSI
    );
endinterface

// File: rtl/spi_ram_master.sv
// Single-clock SPI initiator for the SPI/RAM slave: one host request becomes one framed transfer.
// Optional SPI_RAM_MASTER_ERR_EN rejects rd-data (11) without a preceding rd-addr (10), sticky err.
//
// state   | meaning
// IDLE    | waiting for start, SS_n high
// SEL     | SS_n low, MOSI = cmd[1] for the slave's command check
// SHIFT   | 10 bits {cmd,wdata} out on MOSI, MSB first
// TURN    | read-data only: TURNAROUND idle cycles before sampling
// RECV    | read-data only: 8 MISO samples, MSB first
// GAP     | SS_n high for IDLE_GAP cycles; first cycle carries done
module spi_ram_master #(
    parameter int TURNAROUND = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_ram_master_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_SEL, S_SHIFT, S_TURN, S_RECV, S_GAP} state_t;

    localparam logic [15:0] SHIFT_LOAD = 16'd9;
    localparam logic [15:0] RECV_LOAD  = 16'd7;
    localparam logic [15:0] TURN_LOAD  = 16'(TURNAROUND - 1);
    localparam logic [15:0] GAP_LOAD   = 16'(IDLE_GAP - 1);

    state_t      state_q, state_d;
    logic [9:0]  sr_q, sr_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  rsh_q, rsh_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        rv_q, rv_d;
`ifdef SPI_RAM_MASTER_ERR_EN
    logic        err_q, err_d;
    logic        rd_pend_q, rd_pend_d;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        rsh_d   = rsh_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        rv_d    = 1'b0;
`ifdef SPI_RAM_MASTER_ERR_EN
        err_d     = err_q;
        rd_pend_d = rd_pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sr_d    = {bus.cmd, bus.wdata};
                    cmd_d   = bus.cmd;
                    state_d = S_SEL;
`ifdef SPI_RAM_MASTER_ERR_EN
                    if (bus.cmd == 2'b10) begin
                        rd_pend_d = 1'b1;
                    end else if (bus.cmd == 2'b11) begin
                        if (rd_pend_q) begin
                            rd_pend_d = 1'b0;
                        end else begin
                            // Rejected read: skip the frame, report through done/err only
                            state_d = S_GAP;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            cnt_d   = GAP_LOAD;
                        end
                    end
`endif
                end
            end
            S_SEL: begin
                state_d = S_SHIFT;
                cnt_d   = SHIFT_LOAD;
            end
            S_SHIFT: begin
                sr_d = {sr_q[8:0], 1'b0};
                if (cnt_q == '0) begin
                    if (cmd_q == 2'b11) begin
                        state_d = S_TURN;
                        cnt_d   = TURN_LOAD;
                    end else begin
                        state_d = S_GAP;
                        done_d  = 1'b1;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_TURN: begin
                if (cnt_q == '0) begin
                    state_d = S_RECV;
                    cnt_d   = RECV_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_RECV: begin
                rsh_d = {rsh_q[5:0], bus.MISO};
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    rdata_d = {rsh_q, bus.MISO};
                    done_d  = 1'b1;
                    rv_d    = 1'b1;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            cmd_q     <= '0;
            cnt_q     <= '0;
            rsh_q     <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            rv_q      <= 1'b0;
`ifdef SPI_RAM_MASTER_ERR_EN
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            rsh_q     <= rsh_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            rv_q      <= rv_d;
`ifdef SPI_RAM_MASTER_ERR_EN
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
`endif
        end
    end

    assign bus.SS_n        = ~(state_q inside {S_SEL, S_SHIFT, S_TURN, S_RECV});
    assign bus.MOSI        = (state_q == S_SEL)   ? cmd_q[1] :
                             (state_q == S_SHIFT) ? sr_q[9]  : 1'b0;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rv_q;
`ifdef SPI_RAM_MASTER_ERR_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master: two instances (TURNAROUND/IDLE_GAP = 2/1 and 3/4)
// checked cycle by cycle against a frame-timing model built from the request alone.
module tb_spi_ram_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    spi_ram_master_if ifa();
    spi_ram_master_if ifb();

    spi_ram_master #(.TURNAROUND(2), .IDLE_GAP(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    spi_ram_master #(.TURNAROUND(3), .IDLE_GAP(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    // Reference state per instance
    bit         pend_m [2];
    bit         err_m  [2];
    logic [7:0] rdata_m[2];

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] wdata;
        logic [7:0] reply;
        bit         hold;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input int d, input logic st, input logic [1:0] c, input logic [7:0] w,
                       input logic mi);
        if (d == 0) begin
            ifa.start = st; ifa.cmd = c; ifa.wdata = w; ifa.MISO = mi;
        end else begin
            ifb.start = st; ifb.cmd = c; ifb.wdata = w; ifb.MISO = mi;
        end
    endtask

    task automatic get(input int d, output logic ss, output logic mosi, output logic dn,
                       output logic bz, output logic rv, output logic [7:0] rd, output logic er);
        if (d == 0) begin
            ss = ifa.SS_n; mosi = ifa.MOSI; dn = ifa.done; bz = ifa.busy;
            rv = ifa.rdata_valid; rd = ifa.rdata; er = ifa.err;
        end else begin
            ss = ifb.SS_n; mosi = ifb.MOSI; dn = ifb.done; bz = ifb.busy;
            rv = ifb.rdata_valid; rd = ifb.rdata; er = ifb.err;
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            pend_m[i] = 1'b0; err_m[i] = 1'b0; rdata_m[i] = 8'h00;
        end
    endtask

    // Called at a negedge with the instance idle; returns at the negedge of the first idle cycle.
    task automatic run_frame(input int d, input logic [1:0] c, input logic [7:0] w,
                             input logic [7:0] reply, input bit hold);
        int         ta, gap, flen, n;
        bit         rejected, isrd;
        logic [9:0] word;
        logic       ss, mosi, dn, bz, rv, er, exp_mosi;
        logic [7:0] rd;
        ta  = (d == 0) ? 2 : 3;
        gap = (d == 0) ? 1 : 4;
        rejected = 1'b0;
`ifdef SPI_RAM_MASTER_ERR_EN
        rejected = (c == 2'b11) && !pend_m[d];
        if (!rejected) begin
            if (c == 2'b10) pend_m[d] = 1'b1;
            else if (c == 2'b11) pend_m[d] = 1'b0;
        end
`endif
        isrd = (c == 2'b11) && !rejected;
        flen = rejected ? 0 : (isrd ? 19 + ta : 11);
        n    = flen + gap + 1;
        word = {c, w};
        drv(d, 1'b1, c, w, 1'($urandom_range(0, 1)));
        @(posedge clk);
        if (rejected) err_m[d] = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            drv(d, hold && (k < n), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                (isrd && k >= 12 + ta && k <= 19 + ta) ? reply[19 + ta - k]
                                                       : 1'($urandom_range(0, 1)));
            if (isrd && k == flen + 1) rdata_m[d] = reply;
            exp_mosi = 1'b0;
            if (flen > 0 && k == 1) exp_mosi = c[1];
            else if (flen > 0 && k >= 2 && k <= 11) exp_mosi = word[11 - k];
            get(d, ss, mosi, dn, bz, rv, rd, er);
            chk("SS_n",        32'(ss),   32'(k > flen));
            chk("MOSI",        32'(mosi), 32'(exp_mosi));
            chk("done",        32'(dn),   32'(k == flen + 1));
            chk("busy",        32'(bz),   32'(k <= flen + gap));
            chk("rdata_valid", 32'(rv),   32'(isrd && k == flen + 1));
            chk("rdata",       32'(rd),   32'(rdata_m[d]));
            chk("err",         32'(er),   32'(err_m[d]));
        end
    endtask

    task automatic chk_reset_outputs(input int d);
        logic       ss, mosi, dn, bz, rv, er;
        logic [7:0] rd;
        get(d, ss, mosi, dn, bz, rv, rd, er);
        chk("rst_SS_n",  32'(ss),   32'd1);
        chk("rst_MOSI",  32'(mosi), 32'd0);
        chk("rst_busy",  32'(bz),   32'd0);
        chk("rst_done",  32'(dn),   32'd0);
        chk("rst_rdata", 32'(rd),   32'h00);
        chk("rst_rv",    32'(rv),   32'd0);
        chk("rst_err",   32'(er),   32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] word;
        logic [1:0] rc;
        drv(0, 1'b0, 2'b00, 8'h00, 1'b0);
        drv(1, 1'b0, 2'b00, 8'h00, 1'b0);
        reset_model();
        tbl[0] = '{2'b00, 8'h3A, 8'h00, 1'b0, 8'h00};
        tbl[1] = '{2'b01, 8'hC5, 8'h00, 1'b1, 8'h00};
        tbl[2] = '{2'b10, 8'h3A, 8'h00, 1'b0, 8'h00};
        tbl[3] = '{2'b11, 8'h00, 8'hC5, 1'b0, 8'hC5};
        tbl[4] = '{2'b00, 8'h55, 8'h12, 1'b0, 8'hC5};
        tbl[5] = '{2'b10, 8'h01, 8'h00, 1'b0, 8'hC5};
        tbl[6] = '{2'b11, 8'hFF, 8'hA7, 1'b1, 8'hA7};
        tbl[7] = '{2'b01, 8'h80, 8'h00, 1'b0, 8'hA7};

        repeat (3) @(negedge clk);
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs(0);

        for (int i = 0; i < 8; i++) begin
            run_frame(0, tbl[i].cmd, tbl[i].wdata, tbl[i].reply, tbl[i].hold);
            chk("tbl_rdata", 32'(ifa.rdata), 32'(tbl[i].exp_rdata));
        end

        // Reset during the 5th SHIFT bit of a wr-data frame
        word = {2'b01, 8'h96};
        drv(0, 1'b1, 2'b01, 8'h96, 1'b0);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            drv(0, 1'b0, 2'b00, 8'h00, 1'b0);
        end
        chk("pre_rst_MOSI", 32'(ifa.MOSI), 32'(word[5]));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", 32'(ifa.done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        run_frame(0, 2'b00, 8'h3A, 8'h00, 1'b0);

        // rd-data straight after reset, with no preceding rd-addr
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        run_frame(0, 2'b11, 8'h00, 8'h5A, 1'b0);
        run_frame(0, 2'b10, 8'h20, 8'h00, 1'b0);
        run_frame(0, 2'b11, 8'h00, 8'h3C, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rc = 2'($urandom_range(0, 3));
            run_frame(0, rc, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      $urandom_range(0, 4) == 0);
        end

        run_frame(1, 2'b10, 8'h3A, 8'h00, 1'b0);
        run_frame(1, 2'b11, 8'h00, 8'h96, 1'b0);
        run_frame(1, 2'b01, 8'hC5, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) begin
            rc = 2'($urandom_range(0, 3));
            run_frame(1, rc, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
